uart_rx_oversampled: RTL and testbench

Asynchronous serial receiver for the UART/Bluetooth-to-LCD path. It consumes the single-cycle 16x-oversampling `tick` from the baud-rate generator and samples the line `rxd` from the Bluetooth module. It reconstructs 8N1 frames and presents each byte with a one-cycle `data_valid` strobe to the downstream LCD command/character logic. Start-bit validation, framing-error detection and an optional even-parity check are included.

---
 rtl/uart_rx_oversampled_if.sv | 23 ++
 rtl/uart_rx_oversampled.sv | 184 ++++++++++++++++++
 tb/tb_uart_rx_oversampled.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_oversampled_if.sv
// Receiver-side bundle: oversampling tick and serial line in, byte and status strobes out.
// master drives the line and tick (bench/PHY side); slave is the receiver.
interface uart_rx_oversampled_if #(
    parameter int DATA_BITS = 8
);
    logic                 tick;
    logic                 rxd;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;

    modport master (
        output tick, rxd,
        input  data_out, data_valid, frame_err, parity_err, busy
    );

    modport slave (
        input  tick, rxd,
        output data_out, data_valid, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled UART receiver (8N1; even parity when UART_RX_PARITY_EN is defined).
// Latency: strobes rise one clk after the mid-stop sampling tick, rxd sees a 2-clk synchronizer.
// Backpressure: none; each byte is offered once with a single-cycle data_valid.
module uart_rx_oversampled #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_rx_oversampled_if.slave  bus
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH
    } state_t;
`endif

    state_t               r_state, w_state_nxt;
    logic                 r_sync1, r_sync2;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [DATA_BITS-1:0] r_data_out, w_data_nxt;
    logic                 r_data_valid, w_valid_nxt;
    logic                 r_frame_err, w_ferr_nxt;
    logic                 w_rxs;
`ifdef UART_RX_PARITY_EN
    logic                 r_par, w_par_nxt;
    logic                 r_parity_err, w_perr_nxt;
`endif

    assign w_rxs = r_sync2;

    // Both synchronizer stages reset to the idle line level so reset never fakes a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= bus.rxd;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_shift      <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_idx        <= w_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_data_out   <= w_data_nxt;
            r_data_valid <= w_valid_nxt;
            r_frame_err  <= w_ferr_nxt;
`ifdef UART_RX_PARITY_EN
            r_par        <= w_par_nxt;
            r_parity_err <= w_perr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data_out;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_nxt   = r_par;
        w_perr_nxt  = 1'b0;
`endif
        if (bus.tick) begin
            case (r_state)
                S_IDLE: begin
                    w_cnt_nxt = '0;
                    if (!w_rxs) w_state_nxt = S_START;
                end
                S_START: begin
                    if (r_cnt == CNT_HALF) begin
                        w_cnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_state_nxt = w_rxs ? S_IDLE : S_DATA;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        w_shift_nxt[r_idx] = w_rxs;
                        w_cnt_nxt          = '0;
                        w_idx_nxt          = r_idx + 1'b1;
                        if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            w_state_nxt = S_PARITY;
`else
                            w_state_nxt = S_STOP;
`endif
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt == CNT_LAST) begin
                        w_par_nxt   = w_rxs;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_STOP;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        w_cnt_nxt = '0;
                        if (w_rxs) begin
                            w_state_nxt = S_IDLE;
`ifdef UART_RX_PARITY_EN
                            if (^{r_shift, r_par}) begin
                                w_perr_nxt = 1'b1;
                            end else begin
                                w_valid_nxt = 1'b1;
                                w_data_nxt  = r_shift;
                            end
`else
                            w_valid_nxt = 1'b1;
                            w_data_nxt  = r_shift;
`endif
                        end else begin
                            // A low stop bit may be a break; park until the line returns high.
                            w_ferr_nxt  = 1'b1;
                            w_state_nxt = S_WAIT_HIGH;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    w_cnt_nxt = '0;
                    if (w_rxs) w_state_nxt = S_IDLE;
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.frame_err  = r_frame_err;
    assign bus.busy       = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: frame table plus glitch, back-to-back, reset-abort
// and (with UART_RX_PARITY_EN) parity sequences.
module tb_uart_rx_oversampled;
    localparam int TICK_DIV = 8;
    localparam int OS       = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tdiv = 0;

    uart_rx_oversampled_if #(.DATA_BITS(8)) bus ();

    uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tdiv == TICK_DIV - 1) begin
            tdiv     <= 0;
            bus.tick <= 1'b1;
        end else begin
            tdiv     <= tdiv + 1;
            bus.tick <= 1'b0;
        end
    end

    int         nv = 0, nf = 0, np = 0;
    logic [7:0] vdata [0:63];

    always @(negedge clk) begin
        if (bus.data_valid) begin
            vdata[nv[5:0]] <= bus.data_out;
            nv             <= nv + 1;
        end
        if (bus.frame_err)  nf <= nf + 1;
        if (bus.parity_err) np <= np + 1;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int k;
            k = 0;
            do begin
                @(posedge clk);
                k++;
            end while (!bus.tick && k < 4 * TICK_DIV);
            if (!bus.tick) begin
                checks++;
                failures++;
                $display("FAIL tick_timeout actual=0 required=1");
            end
        end
    endtask

    task automatic drive_bit(input logic b);
        #1 bus.rxd = b;
        wait_ticks(OS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        wait_ticks(1);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop_b);
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_frame_par(input logic [7:0] d, input logic pbit);
        wait_ticks(1);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(pbit);
        drive_bit(1'b1);
    endtask
`endif

    task automatic idle_ticks(input int n);
        #1 bus.rxd = 1'b1;
        wait_ticks(n);
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] dat;
        logic       stop;
        int         hold_low;
        int         exp_vld;
        int         exp_ferr;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs [6];
    int   nv0, nf0, np0;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 0,  1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 20, 0, 1, 8'hA5};
        vecs[2] = '{8'h81, 1'b1, 0,  1, 0, 8'h81};
        vecs[3] = '{8'h00, 1'b1, 0,  1, 0, 8'h00};
        vecs[4] = '{8'h6E, 1'b0, 0,  0, 1, 8'h00};
        vecs[5] = '{8'hFF, 1'b1, 0,  1, 0, 8'hFF};

        bus.rxd = 1'b1;
        rst     = 1'b1;
        repeat (4) @(negedge clk);
        chk("rst_data_out",   bus.data_out,   0);
        chk("rst_data_valid", bus.data_valid, 0);
        chk("rst_frame_err",  bus.frame_err,  0);
        chk("rst_parity_err", bus.parity_err, 0);
        chk("rst_busy",       bus.busy,       0);
        rst = 1'b0;
        wait_ticks(4);

        for (int v = 0; v < 6; v++) begin
            nv0 = nv; nf0 = nf; np0 = np;
            send_frame(vecs[v].dat, vecs[v].stop);
            if (vecs[v].hold_low > 0) begin
                wait_ticks(vecs[v].hold_low);
                @(negedge clk);
                chk($sformatf("v%0d_hold_busy", v), bus.busy, 1);
            end
            idle_ticks(OS);
            chk($sformatf("v%0d_valid_cnt", v), nv - nv0, vecs[v].exp_vld);
            chk($sformatf("v%0d_ferr_cnt", v),  nf - nf0, vecs[v].exp_ferr);
            chk($sformatf("v%0d_perr_cnt", v),  np - np0, 0);
            chk($sformatf("v%0d_data_out", v),  bus.data_out, vecs[v].exp_out);
            chk($sformatf("v%0d_busy_idle", v), bus.busy, 0);
            if (vecs[v].exp_vld == 1)
                chk($sformatf("v%0d_strobe_data", v), vdata[nv0[5:0]], vecs[v].exp_out);
        end

        // Four-tick low glitch: start is detected, then rejected at the mid-start sample.
        nv0 = nv; nf0 = nf;
        wait_ticks(1);
        #1 bus.rxd = 1'b0;
        wait_ticks(4);
        @(negedge clk);
        chk("glitch_busy_mid", bus.busy, 1);
        bus.rxd = 1'b1;
        wait_ticks(8);
        @(negedge clk);
        chk("glitch_busy_end", bus.busy, 0);
        chk("glitch_pulses",   (nv - nv0) + (nf - nf0), 0);
        chk("glitch_data_out", bus.data_out, 8'hFF);

        nv0 = nv;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_ticks(OS);
        chk("b2b_valid_cnt", nv - nv0, 2);
        chk("b2b_first",     vdata[nv0[5:0]], 8'h00);
        chk("b2b_second",    vdata[(nv0 + 1) & 63], 8'hFF);

        // Abort 0x81 after its fourth data bit.
        nv0 = nv; nf0 = nf;
        wait_ticks(1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        @(negedge clk);
        chk("abort_busy_before", bus.busy, 1);
        rst     = 1'b1;
        bus.rxd = 1'b1;
        @(negedge clk);
        chk("abort_rst_data_out",   bus.data_out,   0);
        chk("abort_rst_data_valid", bus.data_valid, 0);
        chk("abort_rst_frame_err",  bus.frame_err,  0);
        chk("abort_rst_parity_err", bus.parity_err, 0);
        chk("abort_rst_busy",       bus.busy,       0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_ticks(4);
        send_frame(8'h5A, 1'b1);
        idle_ticks(OS);
        chk("abort_valid_cnt", nv - nv0, 1);
        chk("abort_ferr_cnt",  nf - nf0, 0);
        chk("abort_data_out",  bus.data_out, 8'h5A);

`ifdef UART_RX_PARITY_EN
        nv0 = nv; np0 = np; nf0 = nf;
        send_frame_par(8'h07, 1'b0);
        idle_ticks(OS);
        chk("par_bad_perr_cnt",  np - np0, 1);
        chk("par_bad_valid_cnt", nv - nv0, 0);
        chk("par_bad_data_out",  bus.data_out, 8'h5A);
        nv0 = nv; np0 = np;
        send_frame_par(8'h07, 1'b1);
        idle_ticks(OS);
        chk("par_good_valid_cnt", nv - nv0, 1);
        chk("par_good_perr_cnt",  np - np0, 0);
        chk("par_good_data_out",  bus.data_out, 8'h07);
        chk("par_ferr_cnt",       nf - nf0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
